// File: rtl/xrisc_mc_controller.sv
// ---------------------------------------------------------------------------
// xrisc_mc_controller
//   Main control FSM for the multicycle XRISC core (lw, sw, R-type, I-type ALU,
//   beq, jal). One state per cycle; drives every datapath select and write
//   strobe, stalls on a memory ready handshake and counts retired instructions.
//
// Parameters
//   HAS_WAIT : 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready, 0 = never wait
//   CNT_W    : width of the instret counter
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   op/funct3/funct7b5    instruction fields from the IR
//   zero                  ALU zero flag (branch decision)
//   mem_ready             memory completes the current access this cycle
//   PCWrite, IRWrite,
//   MemWrite, RegWrite    write strobes (forced 0 while reset is high)
//   AdrSrc, ResultSrc,
//   ALUSrcA, ALUSrcB      datapath selects
//   ImmSrc                immediate format, decoded from op alone
//   ALUControl            ALU operation
//   illegal               one-cycle pulse in DECODE for an unsupported op
//   state_o               current state (debug)
//   instret               retired-instruction count (wraps)
//
// Memory handshake: an access is presented in FETCH, MEMREAD or MEMWRITE and
// completes in the cycle where mem_ready=1. Until then the state and all
// selects hold; IRWrite/PCWrite stay low so nothing commits early, while
// MemWrite remains asserted for the whole access.
// ---------------------------------------------------------------------------
module xrisc_mc_controller #(
  parameter int HAS_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t      state, state_next;
  logic        stall;
  logic        pc_update, branch, ir_en, mem_wr, reg_wr, illegal_d;
  logic [1:0]  alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_en      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    illegal_d  = 1'b0;
    alu_op     = 2'b00;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    stall      = (HAS_WAIT != 0) && !mem_ready &&
                 (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE);
    case (state)
      S_FETCH: begin
        ir_en = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_update = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXECR;
          7'b0010011:             state_next = S_EXECI;
          7'b1101111:             state_next = S_JAL;
          7'b1100011:             state_next = S_BEQ;
          default: begin
            illegal_d  = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1; state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01; reg_wr = 1'b1; state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1; mem_wr = 1'b1; state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10; alu_op = 2'b10; state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = 2'b10; state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr = 1'b1; state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; state_next = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1; state_next = S_FETCH;
      end
      default: state_next = S_FETCH;  // codes 11-15: recover, no strobes
    endcase
    // A held access keeps its selects but must not commit PC/IR early.
    if (stall) begin
      state_next = state;
      ir_en      = 1'b0;
      pc_update  = 1'b0;
    end
  end

  assign PCWrite  = !reset && (pc_update || (branch && zero));
  assign IRWrite  = !reset && ir_en;
  assign MemWrite = !reset && mem_wr;
  assign RegWrite = !reset && reg_wr;
  assign illegal  = !reset && illegal_d;
  assign state_o  = state;

  // Immediate format depends only on the opcode.
  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder. Subtract needs both op[5] (R-type) and funct7b5, so addi
  // with instr[30] set still adds.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Retire on the edge leaving the last state of each legal instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (!stall && (state == S_MEMWB || state == S_MEMWRITE ||
                            state == S_ALUWB || state == S_BEQ)) begin
      instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
